// File: rtl/flash_prog_ctrl.sv
// flash_prog_ctrl: CCTL-mapped ($D5C0-$D5C7) programming sequencer for the
// cartridge's 512 KB JEDEC parallel flash. It issues the unlock/command write
// sequences for byte program, 4 KB sector erase and chip erase, then
// toggle-bit polls DQ6 until the flash finishes or the poll budget runs out.
// Optional feature macro: FLASH_CHIP_ERASE_EN enables CMD $03 (chip erase).
// Without it, $03 is rejected like an unarmed command.
module flash_prog_ctrl #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic        phi2,
    input  logic        reset_n,
    input  logic        cctl_n,
    input  logic        r_w,
    input  logic [7:0]  cart_a,
    input  logic [7:0]  cart_d_in,
    output logic [7:0]  cart_d_out,
    output logic        cart_d_oe,
    output logic [18:0] fl_a,
    input  logic [7:0]  fl_d_in,
    output logic [7:0]  fl_d_out,
    output logic        fl_d_oe,
    output logic        fl_ce_n,
    output logic        fl_oe_n,
    output logic        fl_we_n,
    output logic        fl_own
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LAUNCH,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_P_RD1,
        S_P_RD2,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_PROGRAM,
        OP_SECTOR,
        OP_CHIP
    } op_t;

    localparam logic [18:0] UNLOCK_A = 19'h05555;
    localparam logic [18:0] UNLOCK_B = 19'h02AAA;

    state_t      state;
    op_t         op;
    logic [18:0] addr_reg;
    logic [7:0]  data_reg;
    logic        armed;
    logic        busy;
    logic        err;
    logic        done;
    logic [2:0]  wr_idx;
    logic [19:0] poll_cnt;
    logic        dq6_first;

    logic        reg_sel;
    logic        reg_wr;
    logic        cmd_wr;
    logic        key_wr;
    logic        cmd_known;
    logic        cmd_ok;
    op_t         cmd_op;
    logic [2:0]  next_idx;
    logic [2:0]  last_idx;
    logic [26:0] seq_next;
    logic [18:0] poll_addr;
    logic        poll_expired;
    logic        unused_fl_bits;

    // Address/data pair of write number idx within the unlock/command sequence.
    function automatic logic [26:0] seq_word(
        input op_t         o,
        input logic [2:0]  idx,
        input logic [18:0] a,
        input logic [7:0]  d
    );
        logic [26:0] w;
        w = {UNLOCK_A, 8'hAA};
        case (idx)
            3'd0: w = {UNLOCK_A, 8'hAA};
            3'd1: w = {UNLOCK_B, 8'h55};
            3'd2: w = (o == OP_PROGRAM) ? {UNLOCK_A, 8'hA0} : {UNLOCK_A, 8'h80};
            3'd3: w = (o == OP_PROGRAM) ? {a, d} : {UNLOCK_A, 8'hAA};
            3'd4: w = {UNLOCK_B, 8'h55};
            3'd5: begin
`ifdef FLASH_CHIP_ERASE_EN
                w = (o == OP_CHIP) ? {UNLOCK_A, 8'h10} : {a[18:12], 12'h000, 8'h30};
`else
                w = {a[18:12], 12'h000, 8'h30};
`endif
            end
            default: w = {UNLOCK_A, 8'hAA};
        endcase
        return w;
    endfunction

    assign reg_sel   = ~cctl_n & (cart_a[7:3] == 5'b11000);
    assign reg_wr    = reg_sel & ~r_w;
    assign cmd_wr    = reg_wr & (cart_a[2:0] == 3'd4);
    assign key_wr    = reg_wr & (cart_a[2:0] == 3'd5);
    assign cart_d_oe = reg_sel & r_w;

    // Only DQ6 carries the toggle bit; the rest of the flash read byte is ignored.
    assign unused_fl_bits = ^{fl_d_in[7], fl_d_in[5:0]};

    assign next_idx  = (state == S_W_HOLD) ? (wr_idx + 3'd1) : 3'd0;
    assign last_idx  = (op == OP_PROGRAM) ? 3'd3 : 3'd5;
    assign seq_next  = seq_word(op, next_idx, addr_reg, data_reg);

`ifdef FLASH_CHIP_ERASE_EN
    assign poll_addr = (op == OP_CHIP) ? UNLOCK_A : addr_reg;
`else
    assign poll_addr = addr_reg;
`endif

    // The cycle spent in P_RD2 counts toward the budget, hence the +1.
    assign poll_expired = ({1'b0, poll_cnt} + 21'd1) >= {1'b0, TIMEOUT_CYCLES};

    // Classify a CMD write: known opcodes, and which of them may run.
    always_comb begin
        cmd_known = 1'b0;
        cmd_ok    = 1'b0;
        cmd_op    = OP_PROGRAM;
        case (cart_d_in)
            8'h01: begin
                cmd_known = 1'b1;
                cmd_ok    = 1'b1;
                cmd_op    = OP_PROGRAM;
            end
            8'h02: begin
                cmd_known = 1'b1;
                cmd_ok    = 1'b1;
                cmd_op    = OP_SECTOR;
            end
            8'h03: begin
                cmd_known = 1'b1;
`ifdef FLASH_CHIP_ERASE_EN
                cmd_ok    = 1'b1;
                cmd_op    = OP_CHIP;
`endif
            end
            default: begin
                cmd_known = 1'b0;
            end
        endcase
    end

    // Register read mux for the CCTL window.
    always_comb begin
        cart_d_out = 8'h00;
        if (reg_sel) begin
            case (cart_a[2:0])
                3'd0:    cart_d_out = addr_reg[7:0];
                3'd1:    cart_d_out = addr_reg[15:8];
                3'd2:    cart_d_out = {5'b00000, addr_reg[18:16]};
                3'd3:    cart_d_out = data_reg;
                3'd4:    cart_d_out = {busy, err, 5'b00000, done};
                3'd5:    cart_d_out = {7'b0000000, armed};
                default: cart_d_out = 8'h00;
            endcase
        end
    end

    // ADDR/DATA registers; frozen whenever an operation is in flight.
    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
            data_reg <= '0;
        end else if (reg_wr && (state == S_IDLE)) begin
            case (cart_a[2:0])
                3'd0:    addr_reg[7:0]   <= cart_d_in;
                3'd1:    addr_reg[15:8]  <= cart_d_in;
                3'd2:    addr_reg[18:16] <= cart_d_in[2:0];
                3'd3:    data_reg        <= cart_d_in;
                default: ;
            endcase
        end
    end

    // Sequencer FSM: command acceptance, bus write cycles, toggle-bit polling,
    // status flags and all registered flash-side outputs.
    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op        <= OP_PROGRAM;
            armed     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            wr_idx    <= 3'd0;
            poll_cnt  <= '0;
            dq6_first <= 1'b0;
            fl_a      <= '0;
            fl_d_out  <= '0;
            fl_d_oe   <= 1'b0;
            fl_ce_n   <= 1'b1;
            fl_oe_n   <= 1'b1;
            fl_we_n   <= 1'b1;
            fl_own    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_wr) begin
                        if (cmd_ok && armed) begin
                            op    <= cmd_op;
                            armed <= 1'b0;
                            done  <= 1'b0;
                            err   <= 1'b0;
                            state <= S_LAUNCH;
                        end else if (cmd_known) begin
                            armed <= 1'b0;
                            done  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end else if (key_wr) begin
                        armed <= (cart_d_in == 8'hA5);
                    end
                end
                S_LAUNCH: begin
                    busy     <= 1'b1;
                    fl_own   <= 1'b1;
                    wr_idx   <= 3'd0;
                    fl_a     <= seq_next[26:8];
                    fl_d_out <= seq_next[7:0];
                    fl_d_oe  <= 1'b1;
                    fl_ce_n  <= 1'b0;
                    fl_oe_n  <= 1'b1;
                    fl_we_n  <= 1'b1;
                    state    <= S_W_SETUP;
                end
                S_W_SETUP: begin
                    fl_we_n <= 1'b0;
                    state   <= S_W_STROBE;
                end
                S_W_STROBE: begin
                    fl_we_n <= 1'b1;
                    state   <= S_W_HOLD;
                end
                S_W_HOLD: begin
                    if (wr_idx == last_idx) begin
                        fl_a     <= poll_addr;
                        fl_d_oe  <= 1'b0;
                        fl_oe_n  <= 1'b0;
                        poll_cnt <= '0;
                        state    <= S_P_RD1;
                    end else begin
                        wr_idx   <= next_idx;
                        fl_a     <= seq_next[26:8];
                        fl_d_out <= seq_next[7:0];
                        state    <= S_W_SETUP;
                    end
                end
                S_P_RD1: begin
                    dq6_first <= fl_d_in[6];
                    poll_cnt  <= poll_cnt + 20'd1;
                    state     <= S_P_RD2;
                end
                S_P_RD2: begin
                    poll_cnt <= poll_cnt + 20'd1;
                    if (dq6_first == fl_d_in[6]) begin
                        fl_ce_n <= 1'b1;
                        fl_oe_n <= 1'b1;
                        state   <= S_DONE;
                    end else if (poll_expired) begin
                        fl_ce_n <= 1'b1;
                        fl_oe_n <= 1'b1;
                        state   <= S_ERR;
                    end else begin
                        state <= S_P_RD1;
                    end
                end
                S_DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    fl_own <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    err    <= 1'b1;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    fl_own <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// tb_flash_prog_ctrl: directed + randomized bench for flash_prog_ctrl with a
// behavioural flash (write log and DQ6 toggle generator) and an expected
// command-sequence model built from the JEDEC program/erase rules.
module tb_flash_prog_ctrl;

    localparam logic [19:0] TMO = 20'd100;

    logic        phi2 = 1'b0;
    logic        reset_n = 1'b0;
    logic        cctl_n = 1'b1;
    logic        r_w = 1'b1;
    logic [7:0]  cart_a = 8'h00;
    logic [7:0]  cart_d_in = 8'h00;
    logic [7:0]  cart_d_out;
    logic        cart_d_oe;
    logic [18:0] fl_a;
    logic [7:0]  fl_d_in;
    logic [7:0]  fl_d_out;
    logic        fl_d_oe;
    logic        fl_ce_n;
    logic        fl_oe_n;
    logic        fl_we_n;
    logic        fl_own;

    int total = 0;
    int bad = 0;
    int proto_bad = 0;

    logic [26:0] wr_log[$];
    logic [26:0] exp_q[$];
    int   toggle_len = 0;
    int   toggle_left = 0;
    bit   toggle_forever = 1'b0;
    logic dq6 = 1'b0;

    flash_prog_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .phi2       (phi2),
        .reset_n    (reset_n),
        .cctl_n     (cctl_n),
        .r_w        (r_w),
        .cart_a     (cart_a),
        .cart_d_in  (cart_d_in),
        .cart_d_out (cart_d_out),
        .cart_d_oe  (cart_d_oe),
        .fl_a       (fl_a),
        .fl_d_in    (fl_d_in),
        .fl_d_out   (fl_d_out),
        .fl_d_oe    (fl_d_oe),
        .fl_ce_n    (fl_ce_n),
        .fl_oe_n    (fl_oe_n),
        .fl_we_n    (fl_we_n),
        .fl_own     (fl_own)
    );

    always #5 phi2 = ~phi2;

    assign fl_d_in = {1'b1, dq6, 6'b010101};

    // Behavioural flash: logs each WE strobe, checks strobe legality, and
    // toggles DQ6 for toggle_len cycles after every write (forever if asked).
    always @(posedge phi2) begin
        if (reset_n && fl_own) begin
            if (!fl_we_n && (fl_ce_n || !fl_oe_n || !fl_d_oe)) proto_bad++;
            if (!fl_oe_n && (fl_d_oe || fl_ce_n)) proto_bad++;
        end
        if (reset_n && fl_own && !fl_we_n) begin
            wr_log.push_back({fl_a, fl_d_out});
            toggle_left <= toggle_len;
        end else if (toggle_forever || toggle_left > 0) begin
            dq6 <= ~dq6;
            if (toggle_left > 0) toggle_left <= toggle_left - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        @(negedge phi2);
        cctl_n    = 1'b0;
        r_w       = 1'b0;
        cart_a    = 8'hC0 | a;
        cart_d_in = d;
        @(negedge phi2);
        cctl_n = 1'b1;
        r_w    = 1'b1;
    endtask

    task automatic cctl_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge phi2);
        cctl_n = 1'b0;
        r_w    = 1'b1;
        cart_a = 8'hC0 | a;
        #1;
        d = cart_d_out;
        #1;
        cctl_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_reads, output logic [7:0] st);
        st = 8'hFF;
        for (int i = 0; i < max_reads; i++) begin
            cctl_read(8'h04, st);
            if (!st[7]) break;
        end
        checkOutput("wait_idle_busy", 32'(st[7]), 32'd0);
    endtask

    // Expected bus writes derived from the JEDEC command rules.
    task automatic build_expected(input logic [7:0] cmd, input logic [18:0] a, input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back({19'h05555, 8'hAA});
        exp_q.push_back({19'h02AAA, 8'h55});
        if (cmd == 8'h01) begin
            exp_q.push_back({19'h05555, 8'hA0});
            exp_q.push_back({a, d});
        end else begin
            exp_q.push_back({19'h05555, 8'h80});
            exp_q.push_back({19'h05555, 8'hAA});
            exp_q.push_back({19'h02AAA, 8'h55});
            if (cmd == 8'h03) exp_q.push_back({19'h05555, 8'h10});
            else              exp_q.push_back({a & 19'h7F000, 8'h30});
        end
    endtask

    task automatic compare_writes(input string tag);
        checkOutput($sformatf("%s_count", tag), 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size())
                checkOutput($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic run_op(input logic [7:0] cmd, input logic [18:0] a, input logic [7:0] d);
        wr_log.delete();
        applyStimulus(8'h05, 8'hA5);
        applyStimulus(8'h00, a[7:0]);
        applyStimulus(8'h01, a[15:8]);
        applyStimulus(8'h02, {5'b00000, a[18:16]});
        applyStimulus(8'h03, d);
        applyStimulus(8'h04, cmd);
        build_expected(cmd, a, d);
    endtask

    initial begin
        logic [7:0]  st;
        logic [7:0]  rd;
        logic [18:0] ra;
        logic [7:0]  rdat;

        // Reset state
        repeat (3) @(posedge phi2);
        #1;
        checkOutput("rst_we_n", 32'(fl_we_n), 32'd1);
        checkOutput("rst_ce_n", 32'(fl_ce_n), 32'd1);
        checkOutput("rst_oe_n", 32'(fl_oe_n), 32'd1);
        checkOutput("rst_own", 32'(fl_own), 32'd0);
        checkOutput("rst_d_oe", 32'(fl_d_oe), 32'd0);
        checkOutput("rst_fl_a", 32'(fl_a), 32'd0);
        checkOutput("rst_d_out", 32'(fl_d_out), 32'd0);
        @(negedge phi2);
        reset_n = 1'b1;
        cctl_read(8'h04, st);
        checkOutput("rst_status", 32'(st), 32'h00);
        cctl_read(8'h05, rd);
        checkOutput("rst_key", 32'(rd), 32'h00);

        // Directed program with writes attempted while busy
        $display("[TB] directed program");
        wr_log.delete();
        toggle_len = 20;
        applyStimulus(8'h05, 8'hA5);
        cctl_read(8'h05, rd);
        checkOutput("key_armed", 32'(rd), 32'h01);
        applyStimulus(8'h00, 8'h45);
        applyStimulus(8'h01, 8'h23);
        applyStimulus(8'h02, 8'h01);
        applyStimulus(8'h03, 8'h5A);
        cctl_read(8'h02, rd);
        checkOutput("addr_hi_rd", 32'(rd), 32'h01);
        cctl_read(8'h00, rd);
        checkOutput("addr_lo_rd", 32'(rd), 32'h45);
        applyStimulus(8'h04, 8'h01);
        #1;
        checkOutput("own_before_launch", 32'(fl_own), 32'd0);
        @(posedge phi2);
        #1;
        checkOutput("launch_own", 32'(fl_own), 32'd1);
        checkOutput("launch_ce_n", 32'(fl_ce_n), 32'd0);
        checkOutput("launch_we_n", 32'(fl_we_n), 32'd1);
        checkOutput("launch_d_oe", 32'(fl_d_oe), 32'd1);
        checkOutput("launch_fl_a", 32'(fl_a), 32'h05555);
        checkOutput("launch_d_out", 32'(fl_d_out), 32'hAA);
        applyStimulus(8'h03, 8'hFF);
        applyStimulus(8'h04, 8'h03);
        cctl_read(8'h04, st);
        checkOutput("prog_busy_status", 32'(st), 32'h80);
        cctl_read(8'h05, rd);
        checkOutput("key_cleared", 32'(rd), 32'h00);
        wait_idle(300, st);
        checkOutput("prog_done_status", 32'(st), 32'h01);
        checkOutput("prog_own_dropped", 32'(fl_own), 32'd0);
        cctl_read(8'h03, rd);
        checkOutput("data_kept", 32'(rd), 32'h5A);
        build_expected(8'h01, 19'h12345, 8'h5A);
        compare_writes("prog");

        // Unarmed command
        $display("[TB] unarmed erase");
        wr_log.delete();
        applyStimulus(8'h04, 8'h02);
        repeat (10) @(posedge phi2);
        cctl_read(8'h04, st);
        checkOutput("unarmed_status", 32'(st), 32'h40);
        checkOutput("unarmed_writes", 32'(wr_log.size()), 32'd0);
        checkOutput("unarmed_own", 32'(fl_own), 32'd0);

        // Unknown opcode while armed has no effect
        applyStimulus(8'h05, 8'hA5);
        applyStimulus(8'h04, 8'h07);
        repeat (5) @(posedge phi2);
        cctl_read(8'h04, st);
        checkOutput("badcmd_status", 32'(st), 32'h40);
        cctl_read(8'h05, rd);
        checkOutput("badcmd_key", 32'(rd), 32'h01);
        checkOutput("badcmd_writes", 32'(wr_log.size()), 32'd0);
        applyStimulus(8'h05, 8'h3C);
        cctl_read(8'h05, rd);
        checkOutput("key_disarm", 32'(rd), 32'h00);

        // Randomized programs
        for (int n = 0; n < 3; n++) begin
            ra = 19'($urandom_range(0, 524287));
            rdat = 8'($urandom);
            toggle_len = $urandom_range(1, 40);
            run_op(8'h01, ra, rdat);
            wait_idle(300, st);
            checkOutput($sformatf("rprog%0d_status", n), 32'(st), 32'h01);
            compare_writes($sformatf("rprog%0d", n));
        end

        // Sector erase that never completes
        $display("[TB] sector erase timeout");
        toggle_forever = 1'b1;
        run_op(8'h02, 19'h2ABCD, 8'h00);
        repeat (20) @(posedge phi2);
        cctl_read(8'h04, st);
        checkOutput("tmo_running_status", 32'(st), 32'h80);
        wait_idle(400, st);
        checkOutput("tmo_status", 32'(st), 32'h40);
        checkOutput("tmo_own", 32'(fl_own), 32'd0);
        compare_writes("tmo");
        toggle_forever = 1'b0;

        // Randomized sector erases
        for (int n = 0; n < 2; n++) begin
            ra = 19'($urandom_range(0, 524287));
            toggle_len = $urandom_range(1, 40);
            run_op(8'h02, ra, 8'($urandom));
            wait_idle(300, st);
            checkOutput($sformatf("rsec%0d_status", n), 32'(st), 32'h01);
            compare_writes($sformatf("rsec%0d", n));
        end

        // Chip erase
`ifdef FLASH_CHIP_ERASE_EN
        toggle_len = 10;
        run_op(8'h03, 19'($urandom_range(0, 524287)), 8'h00);
        wait_idle(300, st);
        checkOutput("chip_status", 32'(st), 32'h01);
        compare_writes("chip");
`else
        run_op(8'h03, 19'($urandom_range(0, 524287)), 8'h00);
        repeat (10) @(posedge phi2);
        cctl_read(8'h04, st);
        checkOutput("chip_rejected_status", 32'(st), 32'h40);
        checkOutput("chip_rejected_writes", 32'(wr_log.size()), 32'd0);
        cctl_read(8'h05, rd);
        checkOutput("chip_rejected_key", 32'(rd), 32'h00);
`endif

        // Reset asserted during a WE strobe
        $display("[TB] reset mid-strobe");
        toggle_len = 5;
        run_op(8'h01, 19'h7F0F0, 8'h33);
        for (int i = 0; i < 20; i++) begin
            @(posedge phi2);
            #1;
            if (fl_we_n === 1'b0) break;
        end
        checkOutput("strobe_seen", 32'(fl_we_n), 32'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("arst_we_n", 32'(fl_we_n), 32'd1);
        checkOutput("arst_own", 32'(fl_own), 32'd0);
        checkOutput("arst_ce_n", 32'(fl_ce_n), 32'd1);
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        reset_n = 1'b1;
        cctl_read(8'h04, st);
        checkOutput("arst_status", 32'(st), 32'h00);
        cctl_read(8'h00, rd);
        checkOutput("arst_addr_lo", 32'(rd), 32'h00);

        checkOutput("protocol", 32'(proto_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
